// File: rtl/lookup_pkg.sv
// Shared sizing for the lookup-array front end: requester/port counts, bus widths and index types.
package lookup_pkg;

    localparam int unsigned NUM_REQ   = 8;
    localparam int unsigned NUM_PORTS = 4;
    localparam int unsigned ADDR_W    = 8;
    localparam int unsigned DATA_W    = 8;

    localparam int unsigned REQ_IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned PORT_IDX_W = $clog2(NUM_PORTS);

    typedef logic [REQ_IDX_W-1:0]  req_idx_t;
    typedef logic [PORT_IDX_W-1:0] port_idx_t;

endpackage

// File: rtl/rr_multi_grant.sv
// Combinational round-robin picker: grants up to NUM_PORTS valid requesters starting at rr_i,
// assigning them to ports in scan order, and reports where the next scan should begin.
module rr_multi_grant
    import lookup_pkg::*;
(
    input  logic [NUM_REQ-1:0]   req_valid_i,
    input  req_idx_t             rr_i,
    output logic [NUM_PORTS-1:0] grant_valid_o,
    output req_idx_t             grant_owner_o [NUM_PORTS],
    output req_idx_t             rr_next_o
);

    logic [PORT_IDX_W:0] cnt;
    port_idx_t           slot;
    req_idx_t            idx;

    always_comb begin
        grant_valid_o = '0;
        for (int unsigned k = 0; k < NUM_PORTS; k++) begin
            grant_owner_o[k] = '0;
        end
        rr_next_o = rr_i;
        cnt       = '0;
        slot      = '0;
        idx       = '0;
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
            idx = req_idx_t'((32'(rr_i) + j) % NUM_REQ);
            if (req_valid_i[idx] && (32'(cnt) < NUM_PORTS)) begin
                slot                = port_idx_t'(cnt);
                grant_valid_o[slot] = 1'b1;
                grant_owner_o[slot] = idx;
                cnt                 = cnt + 1'b1;
                // Next scan starts just past the last requester granted this cycle.
                rr_next_o = (32'(idx) == NUM_REQ - 1) ? '0 : idx + 1'b1;
            end
        end
    end

endmodule

// File: rtl/lookup_port_arbiter.sv
// Shares the four array read ports among NUM_REQ requesters: round-robin grant, registered
// array addresses, and per-requester responses two cycles after acceptance.
module lookup_port_arbiter
    import lookup_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         ReqValid,
    input  logic [NUM_REQ*ADDR_W-1:0]  ReqAddr,
    output logic [NUM_REQ-1:0]         ReqReady,
    output logic [NUM_REQ-1:0]         RspValid,
    output logic [NUM_REQ*DATA_W-1:0]  RspData,
    output logic [ADDR_W-1:0]          ArrAddr0,
    output logic [ADDR_W-1:0]          ArrAddr1,
    output logic [ADDR_W-1:0]          ArrAddr2,
    output logic [ADDR_W-1:0]          ArrAddr3,
    input  logic [DATA_W-1:0]          ArrData0,
    input  logic [DATA_W-1:0]          ArrData1,
    input  logic [DATA_W-1:0]          ArrData2,
    input  logic [DATA_W-1:0]          ArrData3
);

    logic [NUM_PORTS-1:0]      grant_valid;
    req_idx_t                  grant_owner [NUM_PORTS];
    req_idx_t                  rr_next;
    logic [DATA_W-1:0]         arr_data [NUM_PORTS];

    req_idx_t                  rr_q, rr_d;
    logic [NUM_PORTS-1:0]      s1_valid_q, s1_valid_d;
    req_idx_t                  s1_owner_q [NUM_PORTS];
    req_idx_t                  s1_owner_d [NUM_PORTS];
    logic [ADDR_W-1:0]         arr_addr_q [NUM_PORTS];
    logic [ADDR_W-1:0]         arr_addr_d [NUM_PORTS];
    logic [NUM_REQ-1:0]        rsp_valid_q, rsp_valid_d;
    logic [NUM_REQ*DATA_W-1:0] rsp_data_q, rsp_data_d;

    rr_multi_grant u_rr_multi_grant (
        .req_valid_i   (ReqValid),
        .rr_i          (rr_q),
        .grant_valid_o (grant_valid),
        .grant_owner_o (grant_owner),
        .rr_next_o     (rr_next)
    );

    assign arr_data[0] = ArrData0;
    assign arr_data[1] = ArrData1;
    assign arr_data[2] = ArrData2;
    assign arr_data[3] = ArrData3;

    // Grants are issued only to valid requesters, so ReqReady alone marks acceptance.
    always_comb begin
        ReqReady = '0;
        if (!reset) begin
            for (int unsigned k = 0; k < NUM_PORTS; k++) begin
                if (grant_valid[k]) ReqReady[grant_owner[k]] = 1'b1;
            end
        end
    end

    always_comb begin
        rr_d        = rr_next;
        arr_addr_d  = arr_addr_q;
        s1_valid_d  = grant_valid;
        s1_owner_d  = grant_owner;
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        for (int unsigned k = 0; k < NUM_PORTS; k++) begin
            if (grant_valid[k]) begin
                arr_addr_d[k] = ReqAddr[32'(grant_owner[k]) * ADDR_W +: ADDR_W];
            end
            if (s1_valid_q[k]) begin
                rsp_valid_d[s1_owner_q[k]]                         = 1'b1;
                rsp_data_d[32'(s1_owner_q[k]) * DATA_W +: DATA_W] = arr_data[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_q        <= '0;
            s1_valid_q  <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            for (int unsigned k = 0; k < NUM_PORTS; k++) begin
                s1_owner_q[k] <= '0;
                arr_addr_q[k] <= '0;
            end
        end else begin
            rr_q        <= rr_d;
            s1_valid_q  <= s1_valid_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            for (int unsigned k = 0; k < NUM_PORTS; k++) begin
                s1_owner_q[k] <= s1_owner_d[k];
                arr_addr_q[k] <= arr_addr_d[k];
            end
        end
    end

    assign RspValid = rsp_valid_q;
    assign RspData  = rsp_data_q;
    assign ArrAddr0 = arr_addr_q[0];
    assign ArrAddr1 = arr_addr_q[1];
    assign ArrAddr2 = arr_addr_q[2];
    assign ArrAddr3 = arr_addr_q[3];

endmodule

// File: tb/tb_lookup_port_arbiter.sv
// Directed bench for lookup_port_arbiter with an identity-table array model (data = address).
module tb_lookup_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  req_valid;
    logic [63:0] req_addr;
    logic [7:0]  req_ready;
    logic [7:0]  rsp_valid;
    logic [63:0] rsp_data;
    logic [7:0]  arr_addr0, arr_addr1, arr_addr2, arr_addr3;
    logic [7:0]  arr_data0, arr_data1, arr_data2, arr_data3;
    logic [31:0] arr_all;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign arr_data0 = arr_addr0;
    assign arr_data1 = arr_addr1;
    assign arr_data2 = arr_addr2;
    assign arr_data3 = arr_addr3;
    assign arr_all   = {arr_addr3, arr_addr2, arr_addr1, arr_addr0};

    lookup_port_arbiter dut (
        .clk      (clk),
        .reset    (reset),
        .ReqValid (req_valid),
        .ReqAddr  (req_addr),
        .ReqReady (req_ready),
        .RspValid (rsp_valid),
        .RspData  (rsp_data),
        .ArrAddr0 (arr_addr0),
        .ArrAddr1 (arr_addr1),
        .ArrAddr2 (arr_addr2),
        .ArrAddr3 (arr_addr3),
        .ArrData0 (arr_data0),
        .ArrData1 (arr_data1),
        .ArrData2 (arr_data2),
        .ArrData3 (arr_data3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_addr(input int i, input logic [7:0] a);
        req_addr[i*8 +: 8] = a;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = 8'hFF;
        req_addr  = '0;
        for (int i = 0; i < 8; i++) set_addr(i, 8'(8'h10 + i));

        // Reset held two cycles with every requester asking.
        repeat (2) tick();
        chk("rst_ready", 64'(req_ready), 64'h00);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'h00);
        chk("rst_rsp_data", rsp_data, 64'h0);
        chk("rst_arr_addr", 64'(arr_all), 64'h0);

        // Full contention for four cycles (C0..C3).
        reset = 1'b0;
        #1;
        chk("c0_ready", 64'(req_ready), 64'h0F);
        tick();
        chk("c1_ready", 64'(req_ready), 64'hF0);
        chk("c1_arr_addr", 64'(arr_all), 64'h13121110);
        chk("c1_rsp_valid", 64'(rsp_valid), 64'h00);
        tick();
        chk("c2_ready", 64'(req_ready), 64'h0F);
        chk("c2_rsp_valid", 64'(rsp_valid), 64'h0F);
        chk("c2_rsp_data", rsp_data, 64'h00000000_13121110);
        chk("c2_arr_addr", 64'(arr_all), 64'h17161514);
        tick();
        chk("c3_ready", 64'(req_ready), 64'hF0);
        chk("c3_rsp_valid", 64'(rsp_valid), 64'hF0);
        chk("c3_rsp_data", rsp_data, 64'h17161514_13121110);
        tick();
        req_valid = 8'h00;
        #1;
        chk("c4_ready_idle", 64'(req_ready), 64'h00);
        chk("c4_rsp_valid", 64'(rsp_valid), 64'h0F);
        tick();
        chk("c5_rsp_valid", 64'(rsp_valid), 64'hF0);
        chk("c5_rsp_data", rsp_data, 64'h17161514_13121110);
        tick();
        chk("c6_rsp_valid", 64'(rsp_valid), 64'h00);

        // Single request from requester 2.
        req_valid = 8'h04;
        set_addr(2, 8'h5A);
        #1;
        chk("single_ready", 64'(req_ready), 64'h04);
        tick();
        req_valid = 8'h00;
        chk("single_arr_addr", 64'(arr_all), 64'h1716155A);
        chk("single_rsp_early", 64'(rsp_valid), 64'h00);
        tick();
        chk("single_rsp_valid", 64'(rsp_valid), 64'h04);
        chk("single_rsp_data", rsp_data, 64'h17161514_135A1110);
        // Probe without acceptance: Rr should now be 3.
        req_valid = 8'hFF;
        #1;
        chk("rr3_probe_ready", 64'(req_ready), 64'h78);

        // Back-to-back from requester 5.
        req_valid = 8'h20;
        set_addr(5, 8'h01);
        #1;
        chk("b2b0_ready", 64'(req_ready), 64'h20);
        tick();
        chk("single_rsp_once", 64'(rsp_valid), 64'h00);
        set_addr(5, 8'h02);
        #1;
        chk("b2b1_ready", 64'(req_ready), 64'h20);
        tick();
        set_addr(5, 8'hFF);
        #1;
        chk("b2b2_ready", 64'(req_ready), 64'h20);
        chk("b2b0_rsp_valid", 64'(rsp_valid), 64'h20);
        chk("b2b0_rsp_data", rsp_data, 64'h17160114_135A1110);
        tick();
        req_valid = 8'h00;
        chk("b2b1_rsp_valid", 64'(rsp_valid), 64'h20);
        chk("b2b1_rsp_data", rsp_data, 64'h17160214_135A1110);
        chk("b2b_arr_addr", 64'(arr_all), 64'h171615FF);
        tick();
        chk("b2b2_rsp_valid", 64'(rsp_valid), 64'h20);
        chk("b2b2_rsp_data", rsp_data, 64'h1716FF14_135A1110);

        // Wrap-around from Rr=6.
        set_addr(6, 8'h66);
        set_addr(7, 8'h77);
        set_addr(0, 8'hA0);
        set_addr(1, 8'hA1);
        req_valid = 8'hFF;
        #1;
        chk("wrap_probe_ready", 64'(req_ready), 64'hC3);
        req_valid = 8'hC3;
        #1;
        chk("wrap_ready", 64'(req_ready), 64'hC3);
        tick();
        req_valid = 8'h00;
        chk("wrap_arr_addr", 64'(arr_all), 64'hA1A07766);
        chk("b2b_rsp_done", 64'(rsp_valid), 64'h00);
        tick();
        chk("wrap_rsp_valid", 64'(rsp_valid), 64'hC3);
        chk("wrap_rsp_data", rsp_data, 64'h7766FF14_135AA1A0);
        req_valid = 8'hFF;
        #1;
        chk("rr2_probe_ready", 64'(req_ready), 64'h3C);

        // Same address from four requesters in one cycle.
        for (int i = 2; i < 6; i++) set_addr(i, 8'h42);
        req_valid = 8'h3C;
        #1;
        chk("same_ready", 64'(req_ready), 64'h3C);
        tick();
        req_valid = 8'h00;
        chk("same_arr_addr", 64'(arr_all), 64'h42424242);
        tick();
        chk("same_rsp_valid", 64'(rsp_valid), 64'h3C);
        chk("same_rsp_data", rsp_data, 64'h77664242_4242A1A0);

        // Mid-flight reset: accept in N, reset in N+1, nothing returns in N+2.
        req_valid = 8'h03;
        #1;
        chk("mid_ready", 64'(req_ready), 64'h03);
        tick();
        reset     = 1'b1;
        req_valid = 8'hFF;
        #1;
        chk("mid_ready_in_reset", 64'(req_ready), 64'h00);
        chk("mid_arr_addr", 64'(arr_all), 64'h4242A1A0);
        req_valid = 8'h00;
        tick();
        reset = 1'b0;
        chk("mid_rsp_valid", 64'(rsp_valid), 64'h00);
        chk("mid_rsp_data", rsp_data, 64'h0);
        chk("mid_arr_addr_clr", 64'(arr_all), 64'h0);
        tick();
        chk("mid_rsp_dropped", 64'(rsp_valid), 64'h00);
        req_valid = 8'hFF;
        #1;
        chk("mid_rr0_probe", 64'(req_ready), 64'h0F);
        req_valid = 8'h00;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
